// File: rtl/shadow_stack_unit_pkg.sv
// Shared types for the shadow return-address stack: address width, event
// record, checker state and default stack depth.
package riscv;
   localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
   localparam int unsigned SS_DEPTH = 16;

   typedef struct packed {
      logic                   valid;
      logic                   call;
      logic                   ret;
      logic [riscv::VLEN-1:0] pc;
      logic [riscv::VLEN-1:0] link;
      logic [riscv::VLEN-1:0] target;
   } ss_event_t;

   typedef enum logic {
      ACTIVE = 1'b0,
      LOCKED = 1'b1
   } ss_state_e;
endpackage

// File: rtl/ss_lifo_ram.sv
// Circular LIFO of return addresses: top pointer, occupancy count and sticky
// overflow. A full stack overwrites its oldest entry instead of refusing a push.
module ss_lifo_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned VLEN  = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [VLEN-1:0]        wdata_i,
   output logic [VLEN-1:0]        rdata_o,
   output logic                   empty_o,
   output logic                   overflow_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [VLEN-1:0] mem_q [DEPTH];
   logic [AW-1:0]   tp_q, tp_d, wptr;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d, we;

   assign rdata_o    = mem_q[tp_q - 1'b1];
   assign empty_o    = (count_q == '0);
   assign overflow_o = ovf_q;
   assign count_o    = count_q;

   // NOTE: every variable gets a default before any branch, so no latch can be inferred.
   always_comb begin
      tp_d    = tp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      we      = 1'b0;
      wptr    = tp_q;
      if (clear_i) begin
         tp_d    = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (push_i && pop_i) begin
         // Swap: the pop frees the top slot and the new link takes it over.
         we = 1'b1;
         if (empty_o) begin
            tp_d    = tp_q + 1'b1;
            count_d = (AW+1)'(1);
         end else begin
            wptr = tp_q - 1'b1;
         end
      end else if (push_i) begin
         we   = 1'b1;
         tp_d = tp_q + 1'b1;
         if (count_q == FULL) ovf_d   = 1'b1;
         else                 count_d = count_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         tp_d    = tp_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         tp_q    <= tp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: storage is not reset; an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (we) mem_q[wptr] <= wdata_i;
   end
endmodule

// File: rtl/shadow_stack_unit.sv
// Shadow return-address stack: pushes on calls, checks returns against the
// popped entry, and locks with a registered violation pulse on mismatch.
module shadow_stack_unit
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = SS_DEPTH,
   parameter int unsigned VLEN  = riscv::VLEN
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   input  logic                   clear_i,
   input  logic                   ev_valid_i,
   input  logic                   ev_call_i,
   input  logic                   ev_ret_i,
   input  logic [VLEN-1:0]        ev_pc_i,
   input  logic [VLEN-1:0]        ev_link_i,
   input  logic [VLEN-1:0]        ev_target_i,
   output logic                   violation_o,
   output logic [VLEN-1:0]        violation_pc_o,
   output logic                   locked_o,
   output logic                   overflow_o,
   output logic [$clog2(DEPTH):0] depth_o
);
   ss_event_t       ev;
   ss_state_e       state_q, state_d;
   logic            accept, push, pop, empty, viol_det;
   logic [VLEN-1:0] top_entry;
   logic            viol_q;
   logic [VLEN-1:0] viol_pc_q;

   assign ev = '{valid:  ev_valid_i,
                 call:   ev_call_i,
                 ret:    ev_ret_i,
                 pc:     ev_pc_i,
                 link:   ev_link_i,
                 target: ev_target_i};

   // clear_i wins over any event presented in the same cycle.
   assign accept = ev.valid & en_i & ~clear_i & (state_q == ACTIVE);
   assign push   = accept & ev.call;
   assign pop    = accept & ev.ret;

   ss_lifo_ram #(
      .DEPTH (DEPTH),
      .VLEN  (VLEN)
   ) u_lifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .push_i     (push),
      .pop_i      (pop),
      .wdata_i    (ev.link),
      .rdata_o    (top_entry),
      .empty_o    (empty),
      .overflow_o (overflow_o),
      .count_o    (depth_o)
   );

   // An empty pop is only tolerated once entries are known to have been lost.
   assign viol_det = pop & (empty ? ~overflow_o : (top_entry != ev.target));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACTIVE: if (viol_det) state_d = LOCKED;
         LOCKED: if (clear_i)  state_d = ACTIVE;
         default:              state_d = ACTIVE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ACTIVE;
         viol_q    <= 1'b0;
         viol_pc_q <= '0;
      end else begin
         state_q <= state_d;
         viol_q  <= viol_det;
         if (clear_i)       viol_pc_q <= '0;
         else if (viol_det) viol_pc_q <= ev.pc;
      end
   end

   assign violation_o    = viol_q;
   assign violation_pc_o = viol_pc_q;
   assign locked_o       = (state_q == LOCKED);
endmodule

// File: tb/tb_shadow_stack_unit.sv
// Directed bench for shadow_stack_unit with hand-computed expectations.
module tb_shadow_stack_unit;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned VLEN  = 64;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            en_i, clear_i;
   logic            ev_valid_i, ev_call_i, ev_ret_i;
   logic [VLEN-1:0] ev_pc_i, ev_link_i, ev_target_i;
   logic            violation_o, locked_o, overflow_o;
   logic [VLEN-1:0] violation_pc_o;
   logic [4:0]      depth_o;

   int n_cmp = 0;
   int n_err = 0;

   shadow_stack_unit #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .en_i           (en_i),
      .clear_i        (clear_i),
      .ev_valid_i     (ev_valid_i),
      .ev_call_i      (ev_call_i),
      .ev_ret_i       (ev_ret_i),
      .ev_pc_i        (ev_pc_i),
      .ev_link_i      (ev_link_i),
      .ev_target_i    (ev_target_i),
      .violation_o    (violation_o),
      .violation_pc_o (violation_pc_o),
      .locked_o       (locked_o),
      .overflow_o     (overflow_o),
      .depth_o        (depth_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one event for a single clock edge, then sample 1 time unit later.
   task automatic event_cycle(input logic call, input logic ret, input logic [63:0] pc,
                              input logic [63:0] link, input logic [63:0] target);
      ev_valid_i  = 1'b1;
      ev_call_i   = call;
      ev_ret_i    = ret;
      ev_pc_i     = pc;
      ev_link_i   = link;
      ev_target_i = target;
      @(posedge clk_i);
      #1;
      ev_valid_i = 1'b0;
      ev_call_i  = 1'b0;
      ev_ret_i   = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_cycle();
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      en_i        = 1'b1;
      clear_i     = 1'b0;
      ev_valid_i  = 1'b0;
      ev_call_i   = 1'b0;
      ev_ret_i    = 1'b0;
      ev_pc_i     = '0;
      ev_link_i   = '0;
      ev_target_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_violation", 64'(violation_o), 64'd0);
      check("reset_vpc", violation_pc_o, 64'd0);
      check("reset_locked", 64'(locked_o), 64'd0);
      check("reset_overflow", 64'(overflow_o), 64'd0);
      check("reset_depth", 64'(depth_o), 64'd0);
      rst_ni = 1'b1;
      #2;

      // Matching call/return.
      event_cycle(1'b1, 1'b0, 64'h1000, 64'h1004, 64'h0);
      check("match_depth1", 64'(depth_o), 64'd1);
      event_cycle(1'b0, 1'b1, 64'h1100, 64'h0, 64'h1004);
      check("match_depth0", 64'(depth_o), 64'd0);
      check("match_noviol", 64'(violation_o), 64'd0);
      check("match_unlocked", 64'(locked_o), 64'd0);

      // Underflow with no overflow history is a violation.
      event_cycle(1'b0, 1'b1, 64'h0777, 64'h0, 64'h40);
      check("uflow_viol", 64'(violation_o), 64'd1);
      check("uflow_vpc", violation_pc_o, 64'h0777);
      check("uflow_locked", 64'(locked_o), 64'd1);
      idle_cycle();
      check("uflow_pulse", 64'(violation_o), 64'd0);
      check("uflow_vpc_hold", violation_pc_o, 64'h0777);

      // Clear while locked drops a simultaneous call.
      clear_i = 1'b1;
      event_cycle(1'b1, 1'b0, 64'h0, 64'h9999, 64'h0);
      clear_i = 1'b0;
      check("clr_unlocked", 64'(locked_o), 64'd0);
      check("clr_depth", 64'(depth_o), 64'd0);
      check("clr_vpc", violation_pc_o, 64'd0);

      // Mismatch, then an event in the cycle the violation registers is ignored.
      event_cycle(1'b1, 1'b0, 64'h2004, 64'h2008, 64'h0);
      event_cycle(1'b0, 1'b1, 64'h5000, 64'h0, 64'h3000);
      check("mm_viol", 64'(violation_o), 64'd1);
      check("mm_vpc", violation_pc_o, 64'h5000);
      check("mm_locked", 64'(locked_o), 64'd1);
      check("mm_depth", 64'(depth_o), 64'd0);
      event_cycle(1'b1, 1'b0, 64'h6000, 64'h6004, 64'h0);
      check("mm_pulse", 64'(violation_o), 64'd0);
      check("mm_frozen_depth", 64'(depth_o), 64'd0);
      check("mm_still_locked", 64'(locked_o), 64'd1);
      clear_cycle();

      // Overflow wrap: 17 calls, 16 matching returns, one tolerated underflow.
      for (int i = 0; i < 17; i++)
         event_cycle(1'b1, 1'b0, 64'h8000, 64'h100 + 64'(i), 64'h0);
      check("ovf_flag", 64'(overflow_o), 64'd1);
      check("ovf_depth", 64'(depth_o), 64'd16);
      for (int i = 0; i < 16; i++) begin
         event_cycle(1'b0, 1'b1, 64'h8800, 64'h0, 64'h110 - 64'(i));
         check($sformatf("ovf_ret%0d", i), 64'(violation_o), 64'd0);
      end
      check("ovf_drained", 64'(depth_o), 64'd0);
      event_cycle(1'b0, 1'b1, 64'h8900, 64'h0, 64'h1234);
      check("ovf_uflow_noviol", 64'(violation_o), 64'd0);
      check("ovf_uflow_unlocked", 64'(locked_o), 64'd0);
      clear_cycle();
      check("ovf_cleared", 64'(overflow_o), 64'd0);

      // Combined call+return swaps the top entry.
      event_cycle(1'b1, 1'b0, 64'h9C, 64'hA0, 64'h0);
      event_cycle(1'b1, 1'b1, 64'hB0, 64'hB4, 64'hA0);
      check("swap_noviol", 64'(violation_o), 64'd0);
      check("swap_depth", 64'(depth_o), 64'd1);
      event_cycle(1'b0, 1'b1, 64'hC0, 64'h0, 64'hB4);
      check("swap_ret_noviol", 64'(violation_o), 64'd0);
      check("swap_ret_depth", 64'(depth_o), 64'd0);

      // Swap on an empty stack with no overflow history: violation, count ends at 1.
      event_cycle(1'b1, 1'b1, 64'hD0, 64'hD4, 64'h0);
      check("swap_empty_viol", 64'(violation_o), 64'd1);
      check("swap_empty_depth", 64'(depth_o), 64'd1);
      clear_cycle();

      // Disabled checking and events that are neither call nor return.
      en_i = 1'b0;
      event_cycle(1'b1, 1'b0, 64'h0, 64'h44, 64'h0);
      check("dis_depth", 64'(depth_o), 64'd0);
      event_cycle(1'b0, 1'b1, 64'h0, 64'h0, 64'h44);
      check("dis_noviol", 64'(violation_o), 64'd0);
      en_i = 1'b1;
      event_cycle(1'b0, 1'b0, 64'h0, 64'h44, 64'h44);
      check("none_depth", 64'(depth_o), 64'd0);

      // Asynchronous reset mid-stream.
      event_cycle(1'b1, 1'b0, 64'h0, 64'h70, 64'h0);
      event_cycle(1'b0, 1'b1, 64'hABC, 64'h0, 64'h71);
      check("pre_rst_locked", 64'(locked_o), 64'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_violation", 64'(violation_o), 64'd0);
      check("rst_vpc", violation_pc_o, 64'd0);
      check("rst_locked", 64'(locked_o), 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      check("rst_depth", 64'(depth_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      event_cycle(1'b1, 1'b0, 64'h0, 64'h80, 64'h0);
      check("post_rst_depth", 64'(depth_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/shadow_stack_unit.md
# shadow_stack_unit

Hardware shadow return-address stack that checks control-flow integrity of committed calls and returns. It sits directly downstream of `branch_unit` and consumes one resolved control-flow event per cycle: calls, returns, or a combined call-and-return. Calls push the return address; returns pop it and compare it with the actual return target. A mismatch raises a registered violation, which the crash path uses to redirect to address 0.

## Interface
Parameters:
- `DEPTH`, 16: stack entries; power of two, ≥ 2.
- `VLEN`, `riscv::VLEN`: address width.

Ports:
- Clock and reset: one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `en_i`, in, 1: checking enabled. When low, no push, pop or violation occurs.
- `clear_i`, in, 1: empties the stack, clears the overflow flag and clears the lock.
- `ev_valid_i`, in, 1: event valid. The block is always ready.
- `ev_call_i`, in, 1: the event is a call (JAL/JALR with rd=x1).
- `ev_ret_i`, in, 1: the event is a return (JALR with rd=x0, rs1=x1).
- `ev_pc_i`, in, VLEN: PC of the instruction.
- `ev_link_i`, in, VLEN: return address to push, given as the decoded next PC.
- `ev_target_i`, in, VLEN: actual decoded jump target.
- `violation_o`, out, 1: one-cycle violation pulse.
- `violation_pc_o`, out, VLEN: PC of the offending return. Holds its value until the next violation or `clear_i`.
- `locked_o`, out, 1: the block is in state LOCKED.
- `overflow_o`, out, 1: sticky flag; at least one entry has been lost.
- `depth_o`, out, $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular stack: `DEPTH` × VLEN entries, a top pointer `tp` of width $clog2(DEPTH), and a count.
- A valid event is accepted only when `ev_valid_i & en_i` holds and the state is ACTIVE.
- **Push (call only):**
  - Write `ev_link_i` at `tp`, then `tp+1` (modulo DEPTH).
  - If count < DEPTH, count increments.
  - If count = DEPTH, the oldest entry is overwritten, count stays at DEPTH and `overflow_o` is set.
- **Pop (return only):**
  - Read the entry at `tp-1`, then set `tp-1` and decrement count.
  - A mismatch between the popped entry and `ev_target_i` is a violation.
  - A return with count = 0 is an underflow:
    - If `overflow_o` = 0, it is a violation.
    - If `overflow_o` = 1, it is not a violation, because the entry may have been lost.
- **Call and return together (coroutine swap):**
  - Pop first and compare the popped entry with the target.
  - Then push `ev_link_i` into the freed slot. Count is unchanged; if count was 0, count ends at 1.
- **State machine:**
  - ACTIVE → LOCKED when a violation is detected.
  - LOCKED → ACTIVE on `clear_i`.
  - In LOCKED, events are ignored and the stack is frozen.
- **`clear_i` priority:** `clear_i` has priority over any event in the same cycle; the event is dropped.
- **Events marked neither call nor return** are ignored.

## Timing
- Reset values: all outputs are 0, state is ACTIVE, `tp` = 0, count = 0. Entry contents are don't-care.
- Push/pop latency: `depth_o` reflects an event 1 cycle after acceptance.
- Comparison is registered:
  - `violation_o` and `violation_pc_o` update on the clock edge after the return event, i.e. 1-cycle latency.
  - `locked_o` rises on that same edge.
- Back-to-back events are accepted every cycle. A return immediately after a call reads the just-pushed entry (write-first bypass is not needed, since the write completes at the edge).
- An event arriving in the same cycle that the violation registers (the cycle after the return) is ignored, because the state is already LOCKED.
- Reset asserted mid-operation clears everything asynchronously. The first event is accepted on the first edge after deassertion.

## Structure
- The shared package `ariane_pkg` holds a `ss_event_t` struct with fields valid, call, ret, pc, link and target.
- `ariane_pkg` also holds a `ss_state_e` enum with values ACTIVE and LOCKED.
- The package holds the constant `SS_DEPTH = 16`.
- One sub-module, `ss_lifo_ram`: a circular storage array with pointer, count and overflow logic.
- The top level holds the compare, the state machine and the output registers.

## Test plan
- **Matching call/return:** push link 0x1004, then return with target 0x1004 → no violation; `depth_o` goes 1 → 0.
- **Mismatch:** push 0x2008, then return with target 0x3000 at pc 0x5000 → next cycle `violation_o` = 1 for one cycle, `violation_pc_o` = 0x5000, `locked_o` = 1; a subsequent call leaves `depth_o` at 0.
- **Overflow wrap:** with DEPTH = 16, perform 17 calls with links 0x100…0x110 → `overflow_o` = 1 and `depth_o` = 16. Then 16 returns with targets 0x110…0x101 → no violation. A 17th return on the empty stack → no violation.
- **Underflow without overflow:** after reset, a return with target 0x40 → violation next cycle.
- **Combined call and return:** push 0xA0, then an event with call = ret = 1, target 0xA0, link 0xB4 → no violation, `depth_o` = 1. A following return with target 0xB4 → no violation.
- **Clear and reset:**
  - In LOCKED, assert `clear_i` together with a call → state ACTIVE, `depth_o` = 0, call dropped.
  - Assert `rst_ni` low mid-stream → all outputs are 0 immediately.
